// File: rtl/data_memory_if.sv
// data_memory_if: core, loader and result-window signals of the data RAM.
// The slave side is the memory; the master side is the core/loader/bench.
interface data_memory_if #(
    parameter int N = 17
);
    logic          write_en;
    logic [11:0]   addr;
    logic [N:0]    datain;
    logic          receive_en;
    logic [11:0]   addr_input;
    logic [N:0]    data_input;
    logic [11:0]   dataout;
    logic [11:0]   r1, r2, r3, r4;
    logic [11:0]   r5, r6, r7, r8;
    logic [11:0]   r9, r10, r11, r12;
    logic [11:0]   r13, r14, r15, r16;

    modport slave (
        input  write_en, addr, datain,
        input  receive_en, addr_input, data_input,
        output dataout,
        output r1, r2, r3, r4, r5, r6, r7, r8,
        output r9, r10, r11, r12, r13, r14, r15, r16
    );

    modport master (
        output write_en, addr, datain,
        output receive_en, addr_input, data_input,
        input  dataout,
        input  r1, r2, r3, r4, r5, r6, r7, r8,
        input  r9, r10, r11, r12, r13, r14, r15, r16
    );
endinterface

// File: rtl/data_memory.sv
// data_memory: 4096x12 data RAM, registered core read and 4x4 result window.
// Loader write port is active only when DM_LOADER_EN is defined.
module data_memory #(
    parameter int N          = 17,
    parameter int R_BASE     = 1032,
    parameter int ROW_STRIDE = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    data_memory_if.slave  bus
);

    logic [11:0] mem_q [4096];
    logic [11:0] dout_q;
    logic [11:0] win_q [16];

    logic        we_d;
    logic [11:0] waddr_d;
    logic [11:0] wdata_d;

    function automatic logic [11:0] win_addr(input int k);
        int a;
        a = (R_BASE + (k / 4) * ROW_STRIDE + (k % 4)) % 4096;
        return 12'(a);
    endfunction

    // Core write has priority; the loader only gets idle core cycles.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = bus.addr;
        wdata_d = bus.datain[11:0];
        if (bus.write_en) begin
            we_d = 1'b1;
        end
`ifdef DM_LOADER_EN
        else if (bus.receive_en) begin
            we_d    = 1'b1;
            waddr_d = bus.addr_input;
            wdata_d = bus.data_input[11:0];
        end
`endif
    end

    // Contents survive reset; writes are simply blocked while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n && we_d) begin
            mem_q[waddr_d] <= wdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            for (int k = 0; k < 16; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            dout_q <= mem_q[bus.addr];
            for (int k = 0; k < 16; k++) begin
                win_q[k] <= mem_q[win_addr(k)];
            end
        end
    end

    assign bus.dataout = dout_q;
    assign bus.r1  = win_q[0];
    assign bus.r2  = win_q[1];
    assign bus.r3  = win_q[2];
    assign bus.r4  = win_q[3];
    assign bus.r5  = win_q[4];
    assign bus.r6  = win_q[5];
    assign bus.r7  = win_q[6];
    assign bus.r8  = win_q[7];
    assign bus.r9  = win_q[8];
    assign bus.r10 = win_q[9];
    assign bus.r11 = win_q[10];
    assign bus.r12 = win_q[11];
    assign bus.r13 = win_q[12];
    assign bus.r14 = win_q[13];
    assign bus.r15 = win_q[14];
    assign bus.r16 = win_q[15];

    logic unused_ok;
    assign unused_ok = ^{bus.datain[N:12], bus.data_input,
                         bus.receive_en, bus.addr_input};

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed and random checks of data_memory against
// an array model of the RAM with written-location tracking.
module tb_data_memory;

    localparam int N = 17;
`ifdef DM_LOADER_EN
    localparam bit LOADER = 1'b1;
`else
    localparam bit LOADER = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   ncmp;
    int   nfail;

    data_memory_if #(.N(N)) bus ();

    data_memory #(
        .N(N),
        .R_BASE(1032),
        .ROW_STRIDE(64)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] rv [16];
    assign rv[0]  = bus.r1;
    assign rv[1]  = bus.r2;
    assign rv[2]  = bus.r3;
    assign rv[3]  = bus.r4;
    assign rv[4]  = bus.r5;
    assign rv[5]  = bus.r6;
    assign rv[6]  = bus.r7;
    assign rv[7]  = bus.r8;
    assign rv[8]  = bus.r9;
    assign rv[9]  = bus.r10;
    assign rv[10] = bus.r11;
    assign rv[11] = bus.r12;
    assign rv[12] = bus.r13;
    assign rv[13] = bus.r14;
    assign rv[14] = bus.r15;
    assign rv[15] = bus.r16;

    logic [11:0] mdl [4096];
    bit          vld [4096];

    function automatic int wa(input int k);
        return 1032 + (k / 4) * 64 + (k % 4);
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout"}, bus.dataout, 12'h000);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s_r%0d", tag, k + 1), rv[k], 12'h000);
        end
    endtask

    // Apply one clock edge with the given inputs and check every output
    // whose source location holds a known value.
    task automatic step(input bit we, input int a, input logic [N:0] d,
                        input bit re, input int ai, input logic [N:0] di,
                        input string tag);
        logic [11:0] ed;
        bit          edv;
        logic [11:0] er [16];
        bit          erv [16];
        bit          run;
        bus.write_en   = we;
        bus.addr       = 12'(a);
        bus.datain     = d;
        bus.receive_en = re;
        bus.addr_input = 12'(ai);
        bus.data_input = di;
        run = (rst_n === 1'b1);
        ed  = mdl[a];
        edv = vld[a];
        for (int k = 0; k < 16; k++) begin
            er[k]  = mdl[wa(k)];
            erv[k] = vld[wa(k)];
        end
        if (run) begin
            if (we) begin
                mdl[a] = d[11:0];
                vld[a] = 1'b1;
            end else if (re && LOADER) begin
                mdl[ai] = di[11:0];
                vld[ai] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (!run) begin
            chk_zero({tag, "_rst"});
        end else begin
            if (edv) chk({tag, "_dout"}, bus.dataout, ed);
            for (int k = 0; k < 16; k++) begin
                if (erv[k]) chk($sformatf("%s_r%0d", tag, k + 1), rv[k], er[k]);
            end
        end
    endtask

    task automatic rd(input int a, input string tag);
        step(1'b0, a, '0, 1'b0, 0, '0, tag);
    endtask

    task automatic wr(input int a, input logic [N:0] d, input string tag);
        step(1'b1, a, d, 1'b0, 0, '0, tag);
    endtask

    task automatic ld(input int a, input logic [N:0] d, input string tag);
        step(1'b0, 0, '0, 1'b1, a, d, tag);
    endtask

    function automatic int rand_addr();
        case ($urandom % 3)
            0:       return wa(int'($urandom % 16));
            1:       return int'($urandom % 32);
            default: return int'($urandom % 4096);
        endcase
    endfunction

    int la [16];

    initial begin
        ncmp  = 0;
        nfail = 0;
        for (int i = 0; i < 4096; i++) begin
            mdl[i] = '0;
            vld[i] = 1'b0;
        end
        rst_n          = 1'b0;
        bus.write_en   = 1'b0;
        bus.addr       = '0;
        bus.datain     = '0;
        bus.receive_en = 1'b0;
        bus.addr_input = '0;
        bus.data_input = '0;
        #1;
        chk_zero("reset_init");
        step(1'b1, 100, 18'h00ABC, 1'b0, 0, '0, "blocked_wr");
        #3;
        rst_n = 1'b1;

        // Core write/read and upper-bit truncation
        wr(100, 18'h00ABC, "wr100");
        rd(100, "rd100");
        wr(101, 18'h3F123, "wr101");
        rd(101, "rd101");
        chk("trunc101", bus.dataout, 12'h123);

        // Loader fill of a 4x4 block
        la = '{8, 9, 10, 11, 72, 73, 74, 75,
               136, 137, 138, 139, 200, 201, 202, 203};
        for (int i = 0; i < 16; i++) begin
            wr(la[i], 18'h00FFF, "prefill");
        end
        for (int i = 0; i < 16; i++) begin
            ld(la[i], 18'(i + 1), "load");
        end
        for (int i = 0; i < 16; i++) begin
            rd(la[i], $sformatf("ldrd%0d", i));
        end

        // Core/loader priority
        wr(6, 18'h00066, "pre6");
        step(1'b1, 5, 18'h00007, 1'b1, 6, 18'h00009, "prio_diff");
        rd(5, "prio_rd5");
        chk("prio5", bus.dataout, 12'h007);
        rd(6, "prio_rd6");
        chk("prio6", bus.dataout, 12'h066);
        step(1'b1, 5, 18'h00007, 1'b1, 5, 18'h00009, "prio_same");
        rd(5, "prio_rd5b");
        chk("prio5b", bus.dataout, 12'h007);

        // Result window and read-first
        wr(1032, 18'h00011, "win1");
        rd(0, "win1_e2");
        chk("r1_val", bus.r1, 12'h011);
        wr(1035, 18'h00022, "win4");
        rd(0, "win4_e2");
        chk("r4_val", bus.r4, 12'h022);
        wr(1224, 18'h00033, "win13");
        rd(0, "win13_e2");
        chk("r13_val", bus.r13, 12'h033);
        wr(1032, 18'h000AA, "rf_a");
        wr(1032, 18'h000BB, "rf_b");
        chk("rf_old", bus.dataout, 12'h0AA);
        rd(1032, "rf_new");
        chk("rf_new_v", bus.dataout, 12'h0BB);

        // Loader at a core-written location
        wr(300, 18'h00111, "pre300");
        ld(300, 18'h00055, "ld300");
        rd(300, "rd300");
        chk("ld300_v", bus.dataout, LOADER ? 12'h055 : 12'h111);

        // Mid-run asynchronous reset
        rd(100, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        step(1'b1, 100, 18'h00FFF, 1'b1, 101, 18'h00EEE, "rst_blk");
        #3;
        rst_n = 1'b1;
        rd(100, "post_rst100");
        chk("post_rst100_v", bus.dataout, 12'hABC);
        rd(101, "post_rst101");

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom % 2), rand_addr(), 18'($urandom),
                 1'($urandom % 2), rand_addr(), 18'($urandom), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
